// File: rtl/ars_mix_driver.sv
// Issue/collect wrapper around a column-serial (Inv)MixColumns engine.
// One input buffer, one output slot, a start/busy FSM with a sticky timeout.
module ars_mix_driver #(
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  input  logic         in_decrypt_i,
  output logic         eng_start_o,
  output logic         eng_decrypt_o,
  output logic [127:0] eng_data_o,
  input  logic         eng_ready_i,
  input  logic [127:0] eng_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o,
  output logic         error_o,
  output logic [15:0]  blk_cnt_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t         state_q, state_d;
  logic           buf_vld_q;
  logic [127:0]   buf_data_q;
  logic           buf_dec_q;
  logic [CW-1:0]  to_cnt_q;
  logic           out_vld_q;
  logic [127:0]   out_data_q;
  logic           err_q;
  logic [15:0]    blk_cnt_q;

  logic cnt_clr, cnt_inc, capture, drop;

  assign in_ready_o    = ~buf_vld_q;
  assign eng_data_o    = buf_data_q;
  assign eng_decrypt_o = buf_dec_q;
  assign eng_start_o   = (state_q == START);
  assign busy_o        = (state_q != IDLE);
  assign out_valid_o   = out_vld_q;
  assign out_data_o    = out_data_q;
  assign error_o       = err_q;
  assign blk_cnt_o     = blk_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Issue only into an empty output slot: the engine result cannot be stalled.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    capture = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE:  if (buf_vld_q && !out_vld_q) state_d = START;
      START: begin
        cnt_clr = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        if (eng_ready_i) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_inc = 1'b1;
          if (to_cnt_q == TO_LAST) begin
            drop    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       to_cnt_q <= '0;
    else if (cnt_clr) to_cnt_q <= '0;
    else if (cnt_inc) to_cnt_q <= to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_vld_q  <= 1'b0;
      buf_data_q <= '0;
      buf_dec_q  <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      buf_vld_q  <= 1'b1;
      buf_data_q <= in_data_i;
      buf_dec_q  <= in_decrypt_i;
    end else if (capture || drop) begin
      buf_vld_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (capture) begin
      out_vld_q  <= 1'b1;
      out_data_q <= eng_data_i;
    end else if (out_vld_q && out_ready_i) begin
      out_vld_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q     <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      if (drop)    err_q     <= 1'b1;
      if (capture) blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_ars_mix_driver.sv
// Randomized scoreboard bench for ars_mix_driver with a behavioural
// (Inv)MixColumns engine model and directed corner scenarios.
module tb_ars_mix_driver;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_decrypt = 1'b0;
  logic         eng_start, eng_decrypt, eng_ready = 1'b0;
  logic [127:0] eng_data_o, eng_data_i = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy, error;
  logic [15:0]  blk_cnt;

  ars_mix_driver #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_decrypt_i(in_decrypt),
    .eng_start_o(eng_start), .eng_decrypt_o(eng_decrypt), .eng_data_o(eng_data_o),
    .eng_ready_i(eng_ready), .eng_data_i(eng_data_i),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .busy_o(busy), .error_o(error), .blk_cnt_o(blk_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  logic [127:0] exp_q[$];
  logic [15:0]  exp_cnt = '0;
  bit           eng_hang = 0, spur = 0, last_dec = 0;
  int           rdy_mode = 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Each column is multiplied by the circulant matrix {2,3,1,1} or {14,11,13,9}.
  function automatic logic [127:0] mix(input logic [127:0] s, input bit dec);
    logic [7:0] m [4];
    logic [127:0] r;
    logic [7:0] acc;
    if (dec) begin m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9; end
    else     begin m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1; end
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(s[127-32*c-8*j -: 8], m[(j - row + 4) % 4]);
        r[127-32*c-8*row -: 8] = acc;
      end
    return r;
  endfunction

  // Engine model: ready on the 4th cycle after the start cycle, operands checked stable.
  initial begin
    int pend;
    logic [127:0] snap_d;
    bit snap_dec;
    pend = 0;
    forever begin
      @(negedge clk);
      eng_ready = 1'b0;
      if (!reset) pend = 0;
      else if (pend > 0) begin
        chk("eng_data_stable", eng_data_o, snap_d);
        chk("eng_dec_stable", {127'b0, eng_decrypt}, {127'b0, snap_dec});
        pend--;
        if (pend == 0) begin
          eng_ready  = 1'b1;
          eng_data_i = mix(snap_d, snap_dec);
        end
      end else if (spur) begin
        eng_ready  = 1'b1;
        eng_data_i = {4{$urandom}};
        spur = 0;
      end
      if (reset && eng_start && !eng_hang) begin
        snap_d = eng_data_o; snap_dec = eng_decrypt; last_dec = eng_decrypt;
        pend = 4;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rdy_mode == 0) out_ready = 1'b0;
    else if (rdy_mode == 1) out_ready = 1'b1;
    else out_ready = 1'($urandom % 2);
  end

  // Monitor: each consumed result pops the scoreboard; the count tracks completions.
  initial forever begin
    @(negedge clk);
    if (reset && out_valid && out_ready) begin
      exp_cnt = exp_cnt + 16'd1;
      if (exp_q.size() == 0) chk("unexpected_output", out_data, 128'hx);
      else chk("out_data", out_data, exp_q.pop_front());
      chk("blk_cnt", {112'b0, blk_cnt}, {112'b0, exp_cnt});
    end
  end

  task automatic send(input logic [127:0] d, input bit dec, input bit push, input logic [127:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_decrypt = dec;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("in_handshake_timeout", {127'b0, in_ready}, 128'd1);
    @(posedge clk);
    if (push) exp_q.push_back(exp);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || busy) && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("drain_timeout", {96'b0, 32'(exp_q.size())}, 128'd0);
  endtask

  // Edges from the handshake edge until the flag is seen high.
  task automatic edges_until(input bit use_err, output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!(use_err ? error : out_valid) && n < 50);
  endtask

  localparam logic [127:0] PT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] CT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  initial begin
    int n;
    logic [127:0] d;
    bit dec;
    int starts;
    logic [15:0] cnt0;

    #12;
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("rst_outs", {123'b0, out_valid, busy, error, eng_start, 1'b0}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_blk_cnt", {112'b0, blk_cnt}, 128'd0);
    @(negedge clk); reset = 1'b1;

    // Known-answer encrypt with latency check
    send(PT, 0, 1, CT);
    edges_until(0, n);
    chk("enc_latency", 128'(n), 128'd6);
    drain();
    chk("enc_blk_cnt", {112'b0, blk_cnt}, 128'd1);

    send(CT, 1, 1, PT);
    drain();
    chk("dec_direction", {127'b0, last_dec}, 128'd1);

    // Backpressure: second block waits in the buffer without issuing
    rdy_mode = 0;
    d = {4{$urandom}}; send(d, 0, 1, mix(d, 0));
    d = {4{$urandom}}; send(d, 1, 1, mix(d, 1));
    starts = 0;
    repeat (20) begin @(negedge clk); if (eng_start) starts++; end
    chk("bp_no_issue", 128'(starts), 128'd0);
    chk("bp_out_held", {127'b0, out_valid}, 128'd1);
    chk("bp_in_blocked", {127'b0, in_ready}, 128'd0);
    rdy_mode = 1;
    drain();

    // Timeout: dropped block, sticky error, count unchanged
    cnt0 = blk_cnt;
    eng_hang = 1;
    send({4{$urandom}}, 0, 0, '0);
    edges_until(1, n);
    chk("to_latency", 128'(n), 128'd10);
    @(negedge clk);
    chk("to_error", {127'b0, error}, 128'd1);
    chk("to_in_ready", {127'b0, in_ready}, 128'd1);
    chk("to_idle", {126'b0, busy, out_valid}, 128'd0);
    chk("to_blk_cnt", {112'b0, blk_cnt}, {112'b0, cnt0});
    eng_hang = 0;
    d = {4{$urandom}}; send(d, 0, 1, mix(d, 0));
    drain();
    chk("to_error_sticky", {127'b0, error}, 128'd1);

    // Random traffic with random downstream readiness
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = {$urandom, $urandom, $urandom, $urandom};
      dec = 1'($urandom % 2);
      send(d, dec, 1, mix(d, dec));
    end
    rdy_mode = 1;
    drain();

    // Counter wrap
    @(negedge clk);
    force dut.blk_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.blk_cnt_q;
    exp_cnt = 16'hFFFF;
    d = {4{$urandom}}; send(d, 1, 1, mix(d, 1));
    drain();
    chk("wrap_blk_cnt", {112'b0, blk_cnt}, 128'd0);

    // Reset mid-BUSY, then spurious engine ready in IDLE
    send({4{$urandom}}, 0, 0, '0);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("mid_busy", {127'b0, busy}, 128'd1);
    reset = 1'b0;
    #1;
    chk("arst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("arst_flags", {124'b0, out_valid, busy, error, eng_start}, 128'd0);
    chk("arst_eng_data", eng_data_o, 128'd0);
    chk("arst_blk_cnt", {112'b0, blk_cnt}, 128'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_cnt = '0;
    reset = 1'b1;
    spur = 1;
    repeat (6) @(negedge clk);
    chk("spur_no_capture", {126'b0, out_valid, busy}, 128'd0);
    chk("spur_out_data", out_data, 128'd0);
    chk("spur_blk_cnt", {112'b0, blk_cnt}, 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

endmodule
